// File: rtl/mips_cpu_state_sequencer.sv
// mips_cpu_state_sequencer
// Multicycle state sequencer for the MIPS-compatible core. Produces the state
// code consumed by the instruction controller, stretches states while the
// memory bus raises waitrequest, and halts the core when the PC reaches 0.
// Optional build macro: MIPS_SEQ_PERF_EN adds the cycle/instruction counters;
// without it both counter outputs are constant zero.
//
//   state   | code | meaning
//   --------+------+------------------------------------------------------
//   IDLE    | 0    | out of reset, core not yet running, datapath held
//   FETCH   | 1    | instruction fetch; halts here when PC is 0
//   DECODE  | 2    | register read / decode, never stalls
//   EXEC1   | 3    | first execute cycle; three-cycle instructions end here
//   EXEC2   | 4    | second execute cycle (loads/stores, etc.)
//   HALTED  | 5    | absorbing until reset; codes 6/7 behave the same
module mips_cpu_state_sequencer #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        threecycle,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        waitrequest,
    input  logic        pc_zero,
    output logic [2:0]  state,
    output logic        hold,
    output logic        active,
    output logic        fault,
    output logic        instr_done,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC1  = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
    localparam bit                TIMEOUT_EN = (MAX_WAIT != 0);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                fault_q, fault_d;
    logic                mem_acc;
    logic                stall;

    assign mem_acc = memread | memwrite;

    // Next-state, hold/instr_done decode and waitrequest timeout
    always_comb begin
        state_d    = state_q;
        hold       = 1'b0;
        instr_done = 1'b0;
        stall      = 1'b0;
        wait_cnt_d = '0;
        fault_d    = fault_q;

        case (state_q)
            S_IDLE: begin
                hold    = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC of zero wins over a pending waitrequest: no read is issued
                if (pc_zero) begin
                    hold    = 1'b1;
                    state_d = S_HALTED;
                end else if (waitrequest) begin
                    hold  = 1'b1;
                    stall = 1'b1;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC1;
            end
            S_EXEC1: begin
                if (mem_acc && waitrequest) begin
                    hold  = 1'b1;
                    stall = 1'b1;
                end else if (threecycle) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC2;
                end
            end
            S_EXEC2: begin
                if (mem_acc && waitrequest) begin
                    hold  = 1'b1;
                    stall = 1'b1;
                end else begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_HALTED: begin
                hold = 1'b1;
            end
            default: begin
                hold    = 1'b1;
                state_d = S_HALTED;
            end
        endcase

        // A held state counts its stall cycles; any state change clears the count
        if (stall) begin
            if (TIMEOUT_EN && (wait_cnt_q == MAX_WAIT_C)) begin
                state_d = S_HALTED;
                fault_d = 1'b1;
            end else if (wait_cnt_q == {WAIT_W{1'b1}}) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end
    end

    // State, wait counter and sticky fault registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    assign state  = state_q;
    assign fault  = fault_q;
    assign active = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_EXEC1) || (state_q == S_EXEC2);

`ifdef MIPS_SEQ_PERF_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] instr_count_q, instr_count_d;

    // Perf counters advance only while running, so they freeze once halted
    always_comb begin
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (active) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
        if (instr_done) begin
            instr_count_d = instr_count_q + 32'd1;
        end
    end

    // Perf counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
`else
    assign cycle_count = 32'h0;
    assign instr_count = 32'h0;
`endif

endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
// Bench for mips_cpu_state_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the sequencing rules.
module tb_mips_cpu_state_sequencer;

    localparam int MAXW = 4;

    logic        clk;
    logic        reset;
    logic        threecycle, memread, memwrite, waitrequest, pc_zero;
    logic [2:0]  state;
    logic        hold, active, fault, instr_done;
    logic [31:0] cycle_count, instr_count;

    int n_cmp = 0;
    int n_bad = 0;

    mips_cpu_state_sequencer #(.MAX_WAIT(MAXW), .WAIT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .threecycle  (threecycle),
        .memread     (memread),
        .memwrite    (memwrite),
        .waitrequest (waitrequest),
        .pc_zero     (pc_zero),
        .state       (state),
        .hold        (hold),
        .active      (active),
        .fault       (fault),
        .instr_done  (instr_done),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus: inputs change just after the edge, the call
    // returns at the following falling edge with outputs settled.
    task automatic cyc(input logic tc, input logic mr, input logic mw,
                       input logic wr, input logic pz);
        @(posedge clk);
        #1;
        threecycle  = tc;
        memread     = mr;
        memwrite    = mw;
        waitrequest = wr;
        pc_zero     = pz;
        @(negedge clk);
    endtask

    // Returns at the falling edge of the IDLE cycle following reset release
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        {threecycle, memread, memwrite, waitrequest, pc_zero} = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // m_run: 0 not started, 1 running, 2 halted
    // m_step: position within the instruction (0 fetch .. 3 second execute)
    int          m_run, m_step, m_wait;
    bit          m_fault;
    logic [31:0] m_cyc, m_ins;
    bit          e_halt_now, e_stall, e_done, e_hold;
    logic [31:0] e_state, e_cyc, e_ins;

    always @(negedge clk) begin
        if (reset) begin
            m_run = 0; m_step = 0; m_wait = 0; m_fault = 0;
            m_cyc = '0; m_ins = '0;
        end
        e_state    = (m_run == 0) ? 32'd0 : (m_run == 2) ? 32'd5 : 32'(m_step + 1);
        e_halt_now = (m_run == 1) && (m_step == 0) && pc_zero;
        e_stall    = (m_run == 1) && !e_halt_now && waitrequest &&
                     ((m_step == 0) || ((m_step >= 2) && (memread || memwrite)));
        e_done     = (m_run == 1) && !e_stall &&
                     (((m_step == 2) && threecycle) || (m_step == 3));
        e_hold     = (m_run != 1) || e_stall || e_halt_now;
`ifdef MIPS_SEQ_PERF_EN
        e_cyc = m_cyc;
        e_ins = m_ins;
`else
        e_cyc = '0;
        e_ins = '0;
`endif
        chk("m_state",  32'(state),      e_state);
        chk("m_hold",   32'(hold),       32'(e_hold));
        chk("m_active", 32'(active),     32'(m_run == 1));
        chk("m_fault",  32'(fault),      32'(m_fault));
        chk("m_done",   32'(instr_done), 32'(e_done));
        chk("m_cycles", cycle_count,     e_cyc);
        chk("m_instrs", instr_count,     e_ins);

        if (!reset) begin
            if (m_run == 0) begin
                m_run = 1; m_step = 0; m_wait = 0;
            end else if (m_run == 1) begin
                m_cyc = m_cyc + 32'd1;
                if (e_done) m_ins = m_ins + 32'd1;
                if (e_stall) begin
                    if (MAXW != 0 && m_wait == MAXW) begin
                        m_run = 2; m_fault = 1;
                    end else begin
                        m_wait++;
                    end
                end else begin
                    m_wait = 0;
                    if (e_halt_now)  m_run = 2;
                    else if (e_done) m_step = 0;
                    else             m_step++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    bit wr_mode;

    initial begin
        reset = 1'b1;
        {threecycle, memread, memwrite, waitrequest, pc_zero} = '0;

        // Three-cycle instruction from reset
        do_reset();
        chk("t1_idle_state", 32'(state), 32'd0);
        chk("t1_idle_hold", 32'(hold), 32'd1);
        chk("t1_idle_active", 32'(active), 32'd0);
        cyc(1, 0, 0, 0, 0);
        chk("t1_fetch", 32'(state), 32'd1);
        chk("t1_active", 32'(active), 32'd1);
        cyc(1, 0, 0, 0, 0);
        chk("t1_decode", 32'(state), 32'd2);
        chk("t1_decode_hold", 32'(hold), 32'd0);
        cyc(1, 0, 0, 0, 0);
        chk("t1_exec1", 32'(state), 32'd3);
        chk("t1_done", 32'(instr_done), 32'd1);
        cyc(1, 0, 0, 0, 0);
        chk("t1_refetch", 32'(state), 32'd1);
        chk("t1_done_off", 32'(instr_done), 32'd0);

        // LW with three waitrequest cycles in EXEC1
        cyc(0, 0, 0, 0, 0);
        chk("t2_decode", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 1, 0);
            chk("t2_stall_state", 32'(state), 32'd3);
            chk("t2_stall_hold", 32'(hold), 32'd1);
            chk("t2_stall_done", 32'(instr_done), 32'd0);
        end
        cyc(0, 1, 0, 0, 0);
        chk("t2_exec1_go", 32'(state), 32'd3);
        chk("t2_exec1_hold", 32'(hold), 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("t2_exec2", 32'(state), 32'd4);
        chk("t2_exec2_done", 32'(instr_done), 32'd1);

        // Fresh stall of MAXW cycles must not fault if the counter cleared
        for (int i = 0; i < MAXW; i++) begin
            cyc(1, 1, 0, 1, 0);
            chk("t2_fetch_stall", 32'(state), 32'd1);
            chk("t2_fetch_hold", 32'(hold), 32'd1);
        end
        cyc(1, 0, 0, 0, 0);
        chk("t2_fetch_go", 32'(state), 32'd1);
        chk("t2_no_fault", 32'(fault), 32'd0);

        // Halt on PC zero after completion
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t3_exec1", 32'(state), 32'd3);
        cyc(1, 0, 0, 1, 1);
        chk("t3_fetch_pz", 32'(state), 32'd1);
        chk("t3_fetch_pz_hold", 32'(hold), 32'd1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("t3_halted", 32'(state), 32'd5);
            chk("t3_inactive", 32'(active), 32'd0);
            chk("t3_hold", 32'(hold), 32'd1);
        end

        // waitrequest stuck in FETCH -> timeout fault
        do_reset();
        for (int i = 0; i < MAXW + 1; i++) begin
            cyc(0, 1, 0, 1, 0);
            chk("t4_fetch_wait", 32'(state), 32'd1);
            chk("t4_fault_pre", 32'(fault), 32'd0);
        end
        cyc(0, 1, 0, 1, 0);
        chk("t4_halted", 32'(state), 32'd5);
        chk("t4_fault", 32'(fault), 32'd1);
        chk("t4_inactive", 32'(active), 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("t4_fault_sticky", 32'(fault), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t4_async_state", 32'(state), 32'd0);
        chk("t4_async_fault", 32'(fault), 32'd0);

        // Asynchronous reset during an EXEC2 stall
        do_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        chk("t5_exec2_stall", 32'(state), 32'd4);
        chk("t5_stall_done", 32'(instr_done), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_state", 32'(state), 32'd0);
        chk("t5_async_fault", 32'(fault), 32'd0);
        chk("t5_async_done", 32'(instr_done), 32'd0);
        chk("t5_async_instrs", instr_count, 32'd0);

        // Ten three-cycle instructions then halt: counter values
        do_reset();
        for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        chk("t6_halt_fetch", 32'(state), 32'd1);
        cyc(0, 0, 0, 0, 0);
        chk("t6_halted", 32'(state), 32'd5);
`ifdef MIPS_SEQ_PERF_EN
        chk("t6_instrs", instr_count, 32'd10);
        chk("t6_cycles", cycle_count, 32'd31);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
        chk("t6_instrs_frozen", instr_count, 32'd10);
        chk("t6_cycles_frozen", cycle_count, 32'd31);
`else
        chk("t6_instrs_zero", instr_count, 32'd0);
        chk("t6_cycles_zero", cycle_count, 32'd0);
`endif

        // Randomized traffic, mid-run resets between segments
        for (int seg = 0; seg < 12; seg++) begin
            @(posedge clk);
            #3;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            wr_mode = 1'b0;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 9) == 0) wr_mode = ~wr_mode;
                cyc(1'($urandom),
                    1'($urandom),
                    ($urandom_range(0, 3) == 0),
                    wr_mode ? 1'b1 : ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 79) == 0));
            end
        end

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_cpu_state_sequencer.md
Name: mips_cpu_state_sequencer

Overview:
Multicycle state sequencer for the MIPS-compatible CPU. Generates the 3-bit state code consumed by the instruction controller: FETCH=1, DECODE=2, EXEC1=3, EXEC2=4. Stalls on memory waitrequest, honours the controller's threecycle indication, and halts the core when the PC reaches address 0. Drives the core's active output and a hold signal that gates all datapath write/read enables.

Parameters:
MAX_WAIT, 255, max consecutive waitrequest cycles tolerated in one state before fault; 0 disables the check
WAIT_W, 8, width of the wait counter; must hold MAX_WAIT

Ports:
clk  input  1  core clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
threecycle  input  1  from controller; instruction completes in EXEC1
memread  input  1  from controller; memory read issued this cycle
memwrite  input  1  from controller; memory write issued this cycle
waitrequest  input  1  memory bus not ready; access must be held
pc_zero  input  1  PC register currently equals 32'h0
state  output  3  current state code to controller
hold  output  1  combinational; when 1 datapath suppresses pcwrite, irwrite, regwrite, memread, memwrite
active  output  1  1 while core executes; 0 in IDLE and HALTED
fault  output  1  sticky; waitrequest timeout occurred
instr_done  output  1  one-cycle pulse on the cycle an instruction completes
cycle_count  output  32  perf counter (see Optional Feature)
instr_count  output  32  perf counter (see Optional Feature)

Behaviour:
- Reset (async, while high): state=IDLE(0), active=0, fault=0, wait counter=0, counters=0. hold=1 in IDLE.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC1=3, EXEC2=4, HALTED=5; codes 6/7 unreachable, treated as HALTED with hold=1.
- IDLE -> FETCH unconditionally on first edge after reset release; active=1 from FETCH onward.
- FETCH: if pc_zero=1 -> hold=1, next HALTED (no read issued). Else if waitrequest=1 -> hold=1, stay. Else -> DECODE.
- DECODE -> EXEC1 always; hold=0.
- EXEC1: mem = memread|memwrite. If mem && waitrequest -> hold=1, stay. Else if threecycle -> FETCH, instr_done=1. Else -> EXEC2.
- EXEC2: if mem && waitrequest -> hold=1, stay. Else -> FETCH, instr_done=1.
- HALTED: absorbing until reset; hold=1, active=0.
- hold=0 in all other cases; hold depends only on state and current-cycle inputs (no added latency).
- Wait counter: increments each cycle the state is held by waitrequest; clears on any state change. If MAX_WAIT!=0 and counter==MAX_WAIT with waitrequest still 1 -> next HALTED, fault=1 (sticky until reset).
- Simultaneous pc_zero and waitrequest in FETCH: pc_zero wins (HALTED).
- instr_done never asserted in a stalled cycle.
- Reset asserted mid-instruction or mid-stall: immediate return to IDLE, no partial completion counted.
- Minimum latency: three-cycle instruction = 3 clocks FETCH->FETCH; LW = 4 clocks plus stalls.

Optional Feature:
MIPS_SEQ_PERF_EN: when defined, cycle_count increments every clock while active=1, instr_count increments on each instr_done; both 32-bit wrapping (0xFFFFFFFF -> 0), cleared by reset, frozen in HALTED. When undefined, both outputs tied to 32'h0 and no counter flops are built.

Test Plan:
- Reset release, pc_zero=0, waitrequest=0, threecycle=1 -> state sequence 0,1,2,3,1; instr_done pulses once; active=1 from cycle 2.
- LW (threecycle=0, memread=1 in EXEC1), waitrequest=1 for 3 cycles in EXEC1 -> state 3 held 4 cycles with hold=1 for 3, then 4, then 1; counter clears.
- Completion with pc_zero=1 on next FETCH -> state 1 for one cycle with hold=1, then 5; active=0; stays 5 for 20 cycles.
- MAX_WAIT=4, waitrequest stuck 1 in FETCH -> HALTED after 5 FETCH cycles, fault=1, active=0.
- Reset asserted asynchronously mid-EXEC2 stall -> state=0, fault=0 immediately, no instr_done.
- With MIPS_SEQ_PERF_EN, 10 three-cycle instructions then halt -> instr_count=10, cycle_count=31 (incl. halting FETCH), both frozen afterwards; without macro both read 0.
